// File: rtl/seq_pkg.sv
// Shared types and defaults for the bit serializer front end.
// The top honours SER_PARITY_EN, which appends an even-parity bit to each frame.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } ser_state_e;

  localparam int SER_WIDTH_DEF = 8;
  localparam int CNT_W         = $clog2(SER_WIDTH_DEF);

endpackage

// File: rtl/seq_ser_shiftreg.sv
// Loadable MSB-first shift register with a down-counter.
// cnt_zero marks the cycle in which the frame's last data bit is on the line.
module seq_ser_shiftreg
  import seq_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             sr_msb,
  output logic             cnt_zero,
  output logic             cnt_one
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = load_data;
      cnt_d = CW'(WIDTH - 1);
    end else if (shift) begin
      sr_d  = {sr_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sr_msb   = sr_q[WIDTH-1];
  assign cnt_zero = (cnt_q == '0);
  assign cnt_one  = (cnt_q == CW'(1));

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: valid/ready words out MSB-first on x_out, zero-gap streaming.
// Define SER_PARITY_EN to append one even-parity bit to every frame.
//
// state     | meaning
// ST_IDLE   | no frame in flight, x_out at IDLE_LEVEL, ready for a word
// ST_SHIFT  | data bits on x_out; the x_out MSB is loaded at accept, the rest comes from sr
// ST_PARITY | parity bit on x_out (SER_PARITY_EN only)
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH      = SER_WIDTH_DEF,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  ser_state_e state_q, state_d;
  logic       x_out_q, x_out_d;
  logic       bit_valid_q, bit_valid_d;
  logic       last_bit_q, last_bit_d;
  logic       sr_msb, cnt_zero, cnt_one;
  logic       accept, shift_en;
`ifdef SER_PARITY_EN
  logic       parity_q, parity_d;
`endif

  seq_ser_shiftreg #(.WIDTH(WIDTH)) u_shiftreg (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .shift     (shift_en),
    .load_data ({in_data[WIDTH-2:0], 1'b0}),
    .sr_msb    (sr_msb),
    .cnt_zero  (cnt_zero),
    .cnt_one   (cnt_one)
  );

`ifdef SER_PARITY_EN
  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_PARITY);
`else
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && cnt_zero);
`endif
  assign accept   = in_valid && in_ready;
  assign shift_en = (state_q == ST_SHIFT) && !cnt_zero;

  always_comb begin
    state_d     = ST_IDLE;
    x_out_d     = IDLE_LEVEL;
    bit_valid_d = 1'b0;
    last_bit_d  = 1'b0;
`ifdef SER_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      ST_SHIFT: begin
        if (!cnt_zero) begin
          state_d     = ST_SHIFT;
          x_out_d     = sr_msb;
          bit_valid_d = 1'b1;
`ifdef SER_PARITY_EN
          last_bit_d  = 1'b0;
`else
          last_bit_d  = cnt_one;
`endif
        end
`ifdef SER_PARITY_EN
        else begin
          state_d     = ST_PARITY;
          x_out_d     = parity_q;
          bit_valid_d = 1'b1;
          last_bit_d  = 1'b1;
        end
`endif
      end
      default: ;
    endcase
    // A new word can only arrive in IDLE or the frame's final cycle, so it overrides all of the above.
    if (accept) begin
      state_d     = ST_SHIFT;
      x_out_d     = in_data[WIDTH-1];
      bit_valid_d = 1'b1;
      last_bit_d  = 1'b0;
`ifdef SER_PARITY_EN
      parity_d    = ^in_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_out_q     <= IDLE_LEVEL;
      bit_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_out_q     <= x_out_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q  <= last_bit_d;
`ifdef SER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign x_out     = x_out_q;
  assign bit_valid = bit_valid_q;
  assign last_bit  = last_bit_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed and randomized checks of seq_bit_serializer (WIDTH=8, IDLE_LEVEL=1).
module tb_seq_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       x_out;
  logic       bit_valid;
  logic       last_bit;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_bit_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .bit_valid (bit_valid),
    .last_bit  (last_bit),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit k of the serial frame for word w: data MSB-first, then parity when enabled.
  function automatic logic frame_bit(input logic [7:0] w, input int k);
    if (k < 8) return w[7-k];
    return ^w;
  endfunction

  task automatic send_single(input logic [7:0] w);
    in_data  = w;
    in_valid = 1'b1;
    chk("single_ready_idle", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    in_data  = ~w;
    for (int k = 0; k < FL; k++) begin
      chk("single_x_out", x_out, frame_bit(w, k));
      chk("single_bit_valid", bit_valid, 1'b1);
      chk("single_last_bit", last_bit, (k == FL - 1));
      chk("single_in_ready", in_ready, (k == FL - 1));
      chk("single_busy", busy, 1'b1);
      step();
    end
    chk("single_after_x_out", x_out, 1'b1);
    chk("single_after_bit_valid", bit_valid, 1'b0);
    chk("single_after_last_bit", last_bit, 1'b0);
    chk("single_after_busy", busy, 1'b0);
  endtask

  initial begin
    int         rem;
    int         acc;
    int         cyc;
    logic [7:0] cur;
    logic [7:0] w;
    logic       acc_now;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    step();
    chk("rst_x_out", x_out, 1'b1);
    chk("rst_bit_valid", bit_valid, 1'b0);
    chk("rst_last_bit", last_bit, 1'b0);
    chk("rst_busy", busy, 1'b0);
    step();
    reset = 1'b0;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_x_out", x_out, 1'b1);

    // Single word 0x36: expected line 0,0,1,1,0,1,1,0 (parity 0 when enabled).
    send_single(8'h36);
    send_single(8'h07);

    // Back-to-back 0xA5 then 0x3C with in_valid held high.
    in_data  = 8'hA5;
    in_valid = 1'b1;
    chk("b2b_ready_idle", in_ready, 1'b1);
    step();
    in_data = 8'h3C;
    for (int i = 0; i < 2 * FL; i++) begin
      w = (i < FL) ? 8'hA5 : 8'h3C;
      chk("b2b_x_out", x_out, frame_bit(w, i % FL));
      chk("b2b_bit_valid", bit_valid, 1'b1);
      chk("b2b_last_bit", last_bit, ((i % FL) == FL - 1));
      chk("b2b_in_ready", in_ready, ((i % FL) == FL - 1));
      step();
      if (i == FL - 1) begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
    end
    chk("b2b_end_bit_valid", bit_valid, 1'b0);
    chk("b2b_end_x_out", x_out, 1'b1);

    // Reset on the 4th bit of 0xFF, with a word offered during reset.
    in_data  = 8'hFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("midrst_pre_busy", busy, 1'b1);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h00;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("midrst_x_out", x_out, 1'b1);
    chk("midrst_bit_valid", bit_valid, 1'b0);
    chk("midrst_last_bit", last_bit, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    step();
    chk("midrst_idle_busy", busy, 1'b0);
    chk("midrst_idle_x_out", x_out, 1'b1);

    // Random in_valid against a cycle-level reference model.
    rem = 0;
    acc = 0;
    cyc = 0;
    cur = 8'h00;
    while (acc < 1000 && cyc < 40000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      chk("rnd_in_ready", in_ready, (rem <= 1));
      acc_now = in_valid && (rem <= 1);
      w       = in_data;
      step();
      cyc++;
      if (acc_now) begin
        cur = w;
        rem = FL;
        acc++;
      end else if (rem > 0) begin
        rem--;
      end
      chk("rnd_x_out", x_out, (rem > 0) ? frame_bit(cur, FL - rem) : 1'b1);
      chk("rnd_bit_valid", bit_valid, (rem > 0));
      chk("rnd_last_bit", last_bit, (rem == 1));
      chk("rnd_busy", busy, (rem > 0));
    end
    chk("rnd_words_accepted", acc, 1000);
    in_valid = 1'b0;
    for (int i = 0; i < FL; i++) step();
    chk("rnd_drain_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
